// File: rtl/count_enable_gen.sv
`default_nettype none
// ============================================================================
// Module      : count_enable_gen
// Description : Upstream stage for the 2-bit synchronous up counters.
//               It turns a raw, possibly bouncing push-button level into the
//               counter toggle-enable `t`. The input is first synchronised
//               with two flip-flops, then debounced, and finally converted to
//               pulses.
//               EDGE mode (mode=0) gives one pulse per debounced press.
//               TICK mode (mode=1) gives a pulse every PRESCALE clocks while
//               the button is held.
// Ports       : clk     - system clock, rising edge
//               rst_n   - synchronous active-low reset
//               btn_in  - raw asynchronous button level, may bounce
//               mode    - 0 = EDGE, 1 = TICK (synchronous to clk)
//               t       - registered count-enable pulse, never two cycles wide
//               btn_db  - registered debounced button level
//               busy    - high while a debounce qualification is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module count_enable_gen #(
  parameter int DEBOUNCE_CYCLES = 4,  // must be >= 2
  parameter int PRESCALE        = 8   // must be >= 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  input  logic mode,
  output logic t,
  output logic btn_db,
  output logic busy
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int PS_W = $clog2(PRESCALE);

  localparam logic [DB_W-1:0] C_DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PS_W-1:0] C_PS_LAST = PS_W'(PRESCALE - 1);

  // Synchroniser
  logic            s1_q;
  logic            s2_q;

  // Debouncer
  logic [DB_W-1:0] db_cnt_q;
  logic [DB_W-1:0] db_cnt_d;
  logic            btn_db_q;
  logic            btn_db_d;
  logic            busy_q;
  logic            busy_d;

  // Pulse generator
  logic            btn_db_prev_q;
  logic            mode_prev_q;
  logic [PS_W-1:0] pre_cnt_q;
  logic [PS_W-1:0] pre_cnt_d;
  logic            t_q;
  logic            t_d;

  logic            w_rise;
  logic            w_mode_chg;
  logic            w_tick_en;
  logic            w_pre_last;

  // --------------------------------------------------------------------------
  // Debouncer: the synchronised level has to differ from btn_db for
  // DEBOUNCE_CYCLES consecutive clocks. Any return to btn_db restarts the
  // qualification from zero.
  // --------------------------------------------------------------------------
  always_comb begin
    db_cnt_d = db_cnt_q;
    btn_db_d = btn_db_q;
    if (s2_q == btn_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == C_DB_LAST) begin
      btn_db_d = s2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
    // Registered from the next count, so busy lines up with db_cnt itself.
    busy_d = (db_cnt_d != '0);
  end

  // --------------------------------------------------------------------------
  // Pulse generator
  // --------------------------------------------------------------------------
  assign w_rise     = btn_db_q & ~btn_db_prev_q;
  assign w_mode_chg = (mode != mode_prev_q);
  assign w_pre_last = (pre_cnt_q == C_PS_LAST);
  // Ticking also needs the debounced level to stay high on this edge. When
  // btn_db falls on the same edge that pre_cnt reaches its last value, the
  // fall wins and no pulse appears after the release.
  assign w_tick_en  = btn_db_q & btn_db_d;

  always_comb begin
    pre_cnt_d = '0;
    t_d       = 1'b0;
    if (w_mode_chg) begin
      // A mode switch silences this edge in both modes, including a rise.
      pre_cnt_d = '0;
      t_d       = 1'b0;
    end else if (!mode) begin
      t_d = w_rise;
    end else if (w_tick_en) begin
      t_d       = w_pre_last;
      pre_cnt_d = w_pre_last ? '0 : pre_cnt_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      db_cnt_q      <= '0;
      btn_db_q      <= 1'b0;
      busy_q        <= 1'b0;
      btn_db_prev_q <= 1'b0;
      mode_prev_q   <= 1'b0;
      pre_cnt_q     <= '0;
      t_q           <= 1'b0;
    end else begin
      s1_q          <= btn_in;
      s2_q          <= s1_q;
      db_cnt_q      <= db_cnt_d;
      btn_db_q      <= btn_db_d;
      busy_q        <= busy_d;
      btn_db_prev_q <= btn_db_q;
      mode_prev_q   <= mode;
      pre_cnt_q     <= pre_cnt_d;
      t_q           <= t_d;
    end
  end

  assign t      = t_q;
  assign btn_db = btn_db_q;
  assign busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_count_enable_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_enable_gen
// Description : Self-checking bench for count_enable_gen. A cycle reference
//               model predicts {t, btn_db, busy} for every clock. Each
//               prediction is queued when the inputs are driven and compared
//               when the outputs are sampled. Scenario-level counts of `t`
//               pulses and a 2-bit counter driven by `t` are also checked.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_enable_gen;

  localparam int DB = 4;
  localparam int PS = 8;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic btn_in = 1'b0;
  logic mode   = 1'b0;
  logic t;
  logic btn_db;
  logic busy;

  count_enable_gen #(
    .DEBOUNCE_CYCLES(DB),
    .PRESCALE       (PS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_in(btn_in),
    .mode  (mode),
    .t     (t),
    .btn_db(btn_db),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Counter fed by t
  logic [1:0] ctr = 2'b00;
  always @(posedge clk) begin
    if (!rst_n)  ctr <= 2'b00;
    else if (t)  ctr <= ctr + 2'b01;
  end

  int n_chk = 0;
  int n_bad = 0;

  logic [2:0] sb_q[$];

  // Reference model state
  logic m_s1 = 0, m_s2 = 0, m_db = 0, m_dbp = 0, m_md = 0, m_t = 0, m_busy = 0;
  int   m_cnt = 0, m_pre = 0;

  // Observation bookkeeping
  int   cyc_n = 0;
  int   t_cnt = 0;
  int   rise_cyc = -1;
  int   first_t_cyc = -1;
  int   base_cyc = 0;
  bit   busy_seen = 0;
  logic db_seen_prev = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic b, input logic m, input logic r);
    logic n_db, n_t, rise;
    int   n_cnt, n_pre;
    if (!r) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_dbp = 0; m_md = 0;
      m_t = 0; m_busy = 0; m_cnt = 0; m_pre = 0;
      return;
    end
    n_db  = m_db;
    n_cnt = m_cnt;
    if (m_s2 == m_db)        n_cnt = 0;
    else if (m_cnt == DB-1) begin n_db = m_s2; n_cnt = 0; end
    else                     n_cnt = m_cnt + 1;
    rise = m_db & ~m_dbp;
    n_t = 0; n_pre = 0;
    if (m != m_md) begin
      n_t = 0; n_pre = 0;
    end else if (!m) begin
      n_t = rise;
    end else if (m_db && n_db) begin
      n_t   = (m_pre == PS-1);
      n_pre = n_t ? 0 : m_pre + 1;
    end
    m_s2 = m_s1; m_s1 = b;
    m_dbp = m_db; m_db = n_db; m_cnt = n_cnt; m_busy = (n_cnt != 0);
    m_pre = n_pre; m_md = m; m_t = n_t;
  endtask

  // One clock: drive at the falling edge, sample at the next falling edge.
  task automatic cyc(input logic b, input logic m, input logic r);
    logic [2:0] e;
    btn_in = b; mode = m; rst_n = r;
    model_step(b, m, r);
    sb_q.push_back({m_t, m_db, m_busy});
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
    chk("sb_depth", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("t", t, e[2]);
      chk("btn_db", btn_db, e[1]);
      chk("busy", busy, e[0]);
    end
    if (t === 1'b1) begin
      t_cnt++;
      if (first_t_cyc < 0) first_t_cyc = cyc_n;
    end
    if (busy === 1'b1) busy_seen = 1;
    if (btn_db === 1'b1 && db_seen_prev !== 1'b1 && rise_cyc < 0) rise_cyc = cyc_n;
    db_seen_prev = btn_db;
  endtask

  task automatic rst_cyc(input logic b, input logic m);
    cyc(b, m, 1'b0);
    t_cnt = 0; busy_seen = 0; first_t_cyc = -1; rise_cyc = -1; base_cyc = cyc_n;
  endtask

  initial begin
    int n;
    @(negedge clk);

    // Reset held 20 ns with the button pressed, then released in EDGE mode
    cyc(1, 0, 0);
    rst_cyc(1, 0);
    chk("rst_t", t, 0);
    chk("rst_db", btn_db, 0);
    chk("rst_busy", busy, 0);
    for (int i = 0; i < 12; i++) cyc(1, 0, 1);
    chk("rst_rise_lat", rise_cyc - base_cyc, DB + 2);
    chk("rst_t_after_rise", first_t_cyc - rise_cyc, 1);
    chk("rst_tcnt", t_cnt, 1);
    chk("rst_ctr", ctr, 1);

    // Bounce rejection in EDGE mode
    rst_cyc(0, 0);
    for (int i = 0; i < 6; i++) cyc((i % 2) == 0, 0, 1);
    for (int i = 0; i < 15; i++) cyc(1, 0, 1);
    chk("bnc_busy_seen", busy_seen, 1);
    chk("bnc_tcnt", t_cnt, 1);
    chk("bnc_ctr", ctr, 1);

    // Three clean presses in EDGE mode
    rst_cyc(0, 0);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 10; i++) cyc(1, 0, 1);
      chk("press_ctr", ctr, p + 1);
      n = t_cnt;
      for (int i = 0; i < 10; i++) cyc(0, 0, 1);
      chk("release_no_t", t_cnt, n);
    end
    chk("press_tcnt", t_cnt, 3);

    // TICK mode, button held 300 ns
    rst_cyc(0, 1);
    for (int i = 0; i < 30; i++) cyc(1, 1, 1);
    for (int i = 0; i < 15; i++) cyc(0, 1, 1);
    chk("tick_first", first_t_cyc - rise_cyc, PS);
    chk("tick_tcnt", t_cnt, 30 / PS);

    // TICK mode, debounced fall lands on the last prescale count
    rst_cyc(0, 1);
    for (int i = 0; i < 40 && !(m_db && m_pre == 2); i++) cyc(1, 1, 1);
    chk("fw_reach", (m_db && m_pre == 2), 1);
    n = t_cnt;
    for (int i = 0; i < 10; i++) cyc(0, 1, 1);
    chk("fw_no_t", t_cnt, n);

    // Mode switch while pre_cnt is at its last count
    rst_cyc(0, 1);
    for (int i = 0; i < 40 && !(m_db && m_pre == PS-1); i++) cyc(1, 1, 1);
    chk("ms_reach", (m_db && m_pre == PS-1), 1);
    cyc(1, 0, 1);
    chk("ms_t", t, 0);
    n = t_cnt;
    for (int i = 0; i < 20; i++) cyc(1, 0, 1);
    chk("ms_hold_no_t", t_cnt, n);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(1, 0, 1);
    chk("ms_next_rise", t_cnt, n + 1);

    // Reset mid-debounce during TICK operation
    rst_cyc(0, 1);
    for (int i = 0; i < 40 && !(m_db && m_pre == 1); i++) cyc(1, 1, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1);
    chk("mr_reach", (m_cnt == 2 && m_pre == 5), 1);
    rst_cyc(0, 1);
    chk("mr_t", t, 0);
    chk("mr_busy", busy, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 1);
    chk("mr_tcnt", t_cnt, 0);
    chk("mr_db", btn_db, 0);
    chk("mr_ctr", ctr, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/count_enable_gen.md
Name: count_enable_gen

Overview:
- Upstream stage for the 2-bit synchronous up counters.
- Conditions a raw, asynchronous push-button or enable level `btn_in` in three steps: 2-FF synchronizer, then debouncer, then pulse generator.
- Drives the counter's toggle-enable `t`.
- EDGE mode: one `t` pulse per debounced press. TICK mode: periodic `t` pulses while the button is held.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles the synchronized input must differ from `btn_db` before `btn_db` changes; legal range ≥2.
- PRESCALE, 8: in TICK mode, `t` period in clocks while `btn_db` is high; legal range ≥2.
- Counter widths are derived internally with $clog2 of each parameter.

Ports:
- clk      input   1  system clock, rising edge
- rst_n    input   1  reset, synchronous, active-low
- btn_in   input   1  raw asynchronous level; may bounce
- mode     input   1  0 = EDGE, 1 = TICK; synchronous to clk
- t        output  1  registered count-enable pulse to the counter
- btn_db   output  1  debounced level, registered
- busy     output  1  high while a debounce qualification is in progress

Behaviour:
- Reset (rst_n=0 at a rising edge) clears: sync FFs s1/s2, db_cnt, btn_db, btn_db_d, pre_cnt, mode_d, t, busy. All outputs read 0 on the following cycle.
- Reset is synchronous only. Asserting rst_n mid-debounce or mid-tick aborts the activity, and no `t` is produced on the reset edge.
- Synchronizer: s1 <= btn_in; s2 <= s1.
- Debouncer:
  - If s2 == btn_db: db_cnt <= 0.
  - Else if db_cnt == DEBOUNCE_CYCLES-1: btn_db <= s2, db_cnt <= 0.
  - Else: db_cnt <= db_cnt+1.
  - Any glitch that returns s2 to btn_db restarts qualification from 0.
  - busy = (db_cnt != 0), registered.
- Latency: for a btn_in change settled before edge k, btn_db changes at edge k+DEBOUNCE_CYCLES+1 (default: 5 edges later).
- Edge detect: btn_db_d <= btn_db; rise = btn_db & ~btn_db_d.
- EDGE mode (mode=0):
  - t <= rise, so `t` is high for exactly one cycle, starting one clock after btn_db goes high.
  - Release (btn_db falling) produces no pulse.
  - pre_cnt is held at 0.
- TICK mode (mode=1):
  - While btn_db=1: pre_cnt <= (pre_cnt==PRESCALE-1) ? 0 : pre_cnt+1, and t <= (pre_cnt==PRESCALE-1).
  - First pulse occurs PRESCALE cycles after btn_db rises, then every PRESCALE cycles.
  - btn_db=0 forces pre_cnt <= 0 and t <= 0.
- Mode change:
  - mode_d <= mode. When mode != mode_d: pre_cnt <= 0 and t <= 0 for that edge, which overrides both the EDGE and TICK rules.
  - A rise that coincides with a mode change is dropped.
- `t` is never high for two consecutive cycles in either mode.
  - TICK mode needs PRESCALE≥2 for this.
  - EDGE mode gets it because btn_db is debounced.
- Simultaneous btn_db fall and pre_cnt==PRESCALE-1: the fall wins, t=0 and pre_cnt=0.

Test Plan (10 ns clock, defaults DEBOUNCE_CYCLES=4, PRESCALE=8, counter driven by t):
- Reset: rst_n=0 for 20 ns with btn_in=1, then release → t, btn_db, busy are 0 throughout reset. btn_db rises 5 edges after release; in mode=0 a single t pulse follows and the counter reads 01.
- Bounce rejection, mode=0: btn_in toggles every 10 ns for 60 ns, then stays at 1 → busy pulses, btn_db rises only after 4 stable synchronized cycles, and exactly one t pulse occurs.
- Three clean presses, mode=0 (each held 100 ns, released 100 ns) → exactly 3 t pulses; counter goes 00→01→10→11; no pulse on any release.
- TICK, mode=1: btn_in held high 300 ns → first t 80 ns after btn_db rises, then every 80 ns. Count of t pulses equals floor(high-time/80 ns); t=0 immediately after btn_db falls.
- Mode switch mid-hold: in TICK mode at pre_cnt=7, toggle mode to 0 → no t on that edge; pre_cnt=0; no further t until the next debounced rise.
- Reset mid-operation: rst_n=0 while db_cnt=2 in TICK mode with pre_cnt=5 → next cycle all state is 0, and no spurious t appears after rst_n returns to 1 with btn_in=0.
